disp_scan_ctrl: RTL and testbench

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

---
 rtl/disp_scan_if.sv | 22 ++
 rtl/disp_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_disp_scan_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/disp_scan_if.sv
// Bus between the display scan controller and its user: scan enable, raw switch
// banks in; digit select, blanking, frame-aligned switch values and frame tick out.
interface disp_scan_if;
  logic       en;
  logic [3:0] sw0_raw;
  logic [3:0] sw1_raw;
  logic       sel;
  logic       blank;
  logic [3:0] s0;
  logic [3:0] s1;
  logic       frame_tick;

  modport master (
    output en, sw0_raw, sw1_raw,
    input  sel, blank, s0, s1, frame_tick
  );

  modport slave (
    input  en, sw0_raw, sw1_raw,
    output sel, blank, s0, s1, frame_tick
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Two-digit display scanner with blanking between select changes, plus a shared
// synchronizer/debouncer for two 4-bit switch banks whose values update once per frame.
module disp_scan_ctrl #(
  parameter int DIV       = 20000,
  parameter int BLANK     = 500,
  parameter int DB_CYCLES = 200000
) (
  input logic       clk,
  input logic       reset_n,
  disp_scan_if.slave bus
);

  localparam int PW_DIV = $clog2(DIV + 1);
  localparam int PW_BLK = $clog2(BLANK + 1);
  localparam int PW     = (PW_DIV > PW_BLK) ? PW_DIV : PW_BLK;
  localparam int DW     = $clog2(DB_CYCLES + 1);

  localparam logic [PW-1:0] DIV_LAST   = PW'(DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {SHOW0, BLANK0, SHOW1, BLANK1} state_t;

  logic [7:0]    raw_vec;
  logic [7:0]    sync1_reg, sync2_reg, prev_reg, db_reg;
  logic [DW-1:0] db_cnt_reg;

  state_t        state_reg, state_next;
  logic [PW-1:0] phase_reg, phase_next;
  logic          sel_reg, blank_reg, tick_reg;
  logic [3:0]    s0_reg, s1_reg;

  assign raw_vec = {bus.sw1_raw, bus.sw0_raw};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_vec;
      sync2_reg <= sync1_reg;
    end
  end

  // Counter parks at DB_LAST while stable, so the accepted value keeps reloading harmlessly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_reg   <= '0;
      db_cnt_reg <= '0;
      db_reg     <= '0;
    end else begin
      prev_reg <= sync2_reg;
      if (sync2_reg != prev_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_LAST) begin
        db_reg <= sync2_reg;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= BLANK1;
      phase_reg <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg + 1'b1;
    if (!bus.en) begin
      state_next = BLANK1;
      phase_next = '0;
    end else begin
      case (state_reg)
        SHOW0: if (phase_reg == DIV_LAST) begin
          state_next = (BLANK > 0) ? BLANK0 : SHOW1;
          phase_next = '0;
        end
        BLANK0: if (phase_reg == BLANK_LAST) begin
          state_next = SHOW1;
          phase_next = '0;
        end
        SHOW1: if (phase_reg == DIV_LAST) begin
          state_next = (BLANK > 0) ? BLANK1 : SHOW0;
          phase_next = '0;
        end
        BLANK1: if (BLANK == 0 || phase_reg == BLANK_LAST) begin
          state_next = SHOW0;
          phase_next = '0;
        end
        default: begin
          state_next = BLANK1;
          phase_next = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register;
  // s0/s1 sample db_reg before any same-edge acceptance lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_reg   <= 1'b0;
      blank_reg <= 1'b1;
      tick_reg  <= 1'b0;
      s0_reg    <= '0;
      s1_reg    <= '0;
    end else begin
      sel_reg   <= (state_next == SHOW1) || (state_next == BLANK1);
      blank_reg <= (state_next == BLANK0) || (state_next == BLANK1);
      tick_reg  <= (state_next == SHOW0) && (state_reg != SHOW0);
      if ((state_next == SHOW0) && (state_reg != SHOW0)) begin
        s0_reg <= db_reg[3:0];
        s1_reg <= db_reg[7:4];
      end
    end
  end

  assign bus.sel        = sel_reg;
  assign bus.blank      = blank_reg;
  assign bus.frame_tick = tick_reg;
  assign bus.s0         = s0_reg;
  assign bus.s1         = s1_reg;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench: main instance DIV=4/BLANK=2/DB_CYCLES=3, second instance DIV=1/BLANK=0/DB_CYCLES=1.
module tb_disp_scan_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  disp_scan_if bus ();
  disp_scan_if fbus ();

  disp_scan_ctrl #(.DIV(4), .BLANK(2), .DB_CYCLES(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  disp_scan_ctrl #(.DIV(1), .BLANK(0), .DB_CYCLES(1)) u_fast (
    .clk(clk), .reset_n(reset_n), .bus(fbus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {sel,blank,frame_tick} n edges after reset release: BLANK1 x2, SHOW0 x4, BLANK0 x2, SHOW1 x4, BLANK1 x2
  function automatic logic [2:0] exp_scan(input int n);
    int p;
    if (n == 1) return 3'b110;
    p = (n - 2) % 12;
    return {p >= 6, (p == 4 || p == 5 || p == 10 || p == 11), p == 0};
  endfunction

  task automatic wait_frame(input string tag);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      seen = bus.frame_tick;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_wait_frame: frame_tick=0 after 30 cycles, required 1", tag);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    bus.en = 1'b1; bus.sw0_raw = 4'h0; bus.sw1_raw = 4'h0;
    fbus.en = 1'b1; fbus.sw0_raw = 4'h0; fbus.sw1_raw = 4'h0;
    #2 reset_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({bus.sel, bus.blank, bus.frame_tick, bus.s0, bus.s1} !== 11'b010_0000_0000) begin
      failures++;
      $display("FAIL reset_main: sel/blank/tick/s0/s1=%b, required 01000000000",
               {bus.sel, bus.blank, bus.frame_tick, bus.s0, bus.s1});
    end
    checks++;
    if ({fbus.sel, fbus.blank, fbus.frame_tick} !== 3'b010) begin
      failures++;
      $display("FAIL reset_fast: sel/blank/tick=%b, required 010",
               {fbus.sel, fbus.blank, fbus.frame_tick});
    end
    $display("reset: main and fast instances held in reset");
  endtask

  // Releases reset and checks the scan sequence of both instances for 26 cycles.
  task automatic test_scan(input string tag);
    logic [2:0] e;
    logic [2:0] fe;
    reset_n = 1'b1;
    for (int n = 1; n <= 26; n++) begin
      step();
      e  = exp_scan(n);
      fe = {(n % 2) == 0, 1'b0, (n % 2) == 1};
      checks++;
      if ({bus.sel, bus.blank, bus.frame_tick} !== e) begin
        failures++;
        $display("FAIL %s_main_cyc%0d: sel/blank/tick=%b, required %b",
                 tag, n, {bus.sel, bus.blank, bus.frame_tick}, e);
      end
      checks++;
      if ({fbus.sel, fbus.blank, fbus.frame_tick} !== fe) begin
        failures++;
        $display("FAIL %s_fast_cyc%0d: sel/blank/tick=%b, required %b",
                 tag, n, {fbus.sel, fbus.blank, fbus.frame_tick}, fe);
      end
    end
    $display("%s: 26 scan cycles compared on both instances", tag);
  endtask

  task automatic test_debounce();
    wait_frame("debounce");
    bus.sw0_raw = 4'h5; bus.sw1_raw = 4'hA;
    for (int i = 1; i <= 11; i++) begin
      step();
      checks++;
      if ({bus.frame_tick, bus.s1, bus.s0} !== 9'h000) begin
        failures++;
        $display("FAIL debounce_hold_cyc%0d: tick/s1/s0=%h, required 000",
                 i, {bus.frame_tick, bus.s1, bus.s0});
      end
    end
    step();
    checks++;
    if ({bus.frame_tick, bus.s1, bus.s0} !== 9'h1A5) begin
      failures++;
      $display("FAIL debounce_frame: tick/s1/s0=%h, required 1a5",
               {bus.frame_tick, bus.s1, bus.s0});
    end
    $display("debounce: 5/A presented at next frame start");
  endtask

  task automatic test_glitch();
    bus.sw0_raw = 4'h3;
    repeat (30) step();
    checks++;
    if (bus.s0 !== 4'h3) begin
      failures++;
      $display("FAIL glitch_settle: s0=%h, required 3", bus.s0);
    end
    for (int i = 0; i < 20; i++) begin
      bus.sw0_raw = ((i / 2) % 2 == 1) ? 4'h7 : 4'h3;
      step();
      checks++;
      if (bus.s0 !== 4'h3) begin
        failures++;
        $display("FAIL glitch_cyc%0d: s0=%h, required 3", i, bus.s0);
      end
    end
    bus.sw0_raw = 4'h3;
    $display("glitch: s0 held at 3 through 20 toggling cycles");
  endtask

  task automatic test_en();
    wait_frame("en");
    step();
    bus.en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if ({bus.sel, bus.blank, bus.frame_tick} !== 3'b110) begin
        failures++;
        $display("FAIL en_low_cyc%0d: sel/blank/tick=%b, required 110",
                 i, {bus.sel, bus.blank, bus.frame_tick});
      end
    end
    checks++;
    if (bus.s0 !== 4'h3) begin
      failures++;
      $display("FAIL en_low_s0: s0=%h, required 3", bus.s0);
    end
    bus.en = 1'b1;
    step();
    checks++;
    if ({bus.sel, bus.blank, bus.frame_tick} !== 3'b110) begin
      failures++;
      $display("FAIL en_rise_blank: sel/blank/tick=%b, required 110",
               {bus.sel, bus.blank, bus.frame_tick});
    end
    step();
    checks++;
    if ({bus.sel, bus.blank, bus.frame_tick} !== 3'b001) begin
      failures++;
      $display("FAIL en_rise_frame: sel/blank/tick=%b, required 001",
               {bus.sel, bus.blank, bus.frame_tick});
    end
    $display("en: blank hold then frame restart after two blank cycles");
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    bus.sw0_raw = 4'h5;
    repeat (30) step();
    checks++;
    if (bus.s0 !== 4'h5) begin
      failures++;
      $display("FAIL reset_mid_pre_s0: s0=%h, required 5", bus.s0);
    end
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = bus.sel && !bus.blank;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reset_mid_find_show1: SHOW1 not seen in 30 cycles, required seen");
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.sel, bus.blank, bus.frame_tick, bus.s0, bus.s1} !== 11'b010_0000_0000) begin
      failures++;
      $display("FAIL reset_mid_async: sel/blank/tick/s0/s1=%b, required 01000000000",
               {bus.sel, bus.blank, bus.frame_tick, bus.s0, bus.s1});
    end
    repeat (2) step();
    $display("reset_mid: asynchronous reset from SHOW1 applied");
  endtask

  task automatic test_fast_switch();
    fbus.sw0_raw = 4'h9;
    repeat (8) step();
    checks++;
    if (fbus.s0 !== 4'h9) begin
      failures++;
      $display("FAIL fast_switch_s0: s0=%h, required 9", fbus.s0);
    end
    $display("fast_switch: single-cycle debounce delivered 9");
  endtask

  initial begin
    test_reset();
    test_scan("scan");
    test_debounce();
    test_glitch();
    test_en();
    test_reset_mid();
    test_scan("restart");
    test_fast_switch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
